// File: rtl/axi_i2s_lite_slave.sv
// rtl/axi_i2s_lite_slave.sv - AXI4-Lite register slave with sample FIFO feeding the I2S serializer (option: AXI_I2S_IRQ_EN adds irq output)
module axi_i2s_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [31:0]                     smp_data,
    output logic                            smp_valid,
    input  logic                            smp_ready,
    output logic                            i2s_en,
    output logic [15:0]                     clkdiv
`ifdef AXI_I2S_IRQ_EN
    ,
    output logic                            irq
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic          rst_done;
    logic          aw_held, w_held;
    logic [1:0]    aw_sel_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic          bvalid_q, rvalid_q;
    logic [1:0]    bresp_q;
    logic [31:0]   rdata_q;
    logic          ctrl_en;
    logic [15:0]   clkdiv_q;
    logic [31:0]   last_sample;
    logic          ovf;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [3:0]    irq_thresh;
    logic [3:0]    irq_thresh_next;
    logic          en_next;

    assign S_AXI_AWREADY = rst_done & ~aw_held & ~bvalid_q;
    assign S_AXI_WREADY  = rst_done & ~w_held & ~bvalid_q;
    assign S_AXI_ARREADY = rst_done & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    wire aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    wire w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    wire ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    // A write uses whichever of address/data was parked earlier, else the live bus value
    wire [1:0]  wr_sel  = aw_held ? aw_sel_q : S_AXI_AWADDR[3:2];
    wire [31:0] wr_data = w_held ? w_data_q : S_AXI_WDATA;
    wire [3:0]  wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
    wire        commit  = (aw_held | aw_hs) & (w_held | w_hs);

    wire fifo_full  = (count == CW'(FIFO_DEPTH));
    wire fifo_empty = (count == '0);
    wire pop        = smp_valid & smp_ready;
    wire sample_wr  = commit & (wr_sel == 2'd2);
    wire push       = sample_wr & ~fifo_full;
    wire push_err   = sample_wr & fifo_full;
    wire ctrl_wr    = commit & (wr_sel == 2'd0);
    wire flush      = ctrl_wr & wr_strb[0] & wr_data[1];
    wire ovf_clr    = commit & (wr_sel == 2'd3) & wr_data[10];

    assign smp_valid = ctrl_en & ~fifo_empty;
    assign smp_data  = mem[rd_ptr];
    assign i2s_en    = ctrl_en;
    assign clkdiv    = clkdiv_q;

    wire unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], wr_strb[3:2], irq_thresh_next};

    logic [31:0] ctrl_word, status_word, rd_word;

    // Register read views and next-state values seen by the FIFO and irq logic
    always_comb begin
        ctrl_word       = '0;
        ctrl_word[0]    = ctrl_en;
        irq_thresh_next = irq_thresh;
`ifdef AXI_I2S_IRQ_EN
        ctrl_word[11:8] = irq_thresh;
        if (ctrl_wr && wr_strb[1]) irq_thresh_next = wr_data[11:8];
`endif
        en_next     = (ctrl_wr && wr_strb[0]) ? wr_data[0] : ctrl_en;
        status_word = {21'd0, ovf, fifo_empty, fifo_full, 8'(count)};
        count_next  = count;
        if (flush)             count_next = '0;
        else if (push && !pop) count_next = count + CW'(1);
        else if (pop && !push) count_next = count - CW'(1);
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_word = ctrl_word;
            2'd1:    rd_word = {16'd0, clkdiv_q};
            2'd2:    rd_word = last_sample;
            default: rd_word = status_word;
        endcase
    end

    // Ready outputs stay low until one clock edge after reset release
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // Write channel: park AW and W independently, commit once both are present
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_sel_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= push_err ? 2'b10 : 2'b00;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_sel_q <= S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
        end
    end

    // Read channel: capture pre-write register contents on the AR handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // Control registers, overflow flag and last accepted sample
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en     <= 1'b0;
            clkdiv_q    <= '0;
            last_sample <= '0;
            ovf         <= 1'b0;
            irq_thresh  <= '0;
        end else begin
            ctrl_en    <= en_next;
            irq_thresh <= irq_thresh_next;
            if (commit && wr_sel == 2'd1) begin
                if (wr_strb[0]) clkdiv_q[7:0]  <= wr_data[7:0];
                if (wr_strb[1]) clkdiv_q[15:8] <= wr_data[15:8];
            end
            if (push)          last_sample <= wr_data;
            if (push_err)      ovf <= 1'b1;
            else if (ovf_clr)  ovf <= 1'b0;
        end
    end

    // Sample FIFO; flush overrides any same-cycle pop
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= wr_data;
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef AXI_I2S_IRQ_EN
    // Level interrupt computed from the post-update FIFO level
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq <= 1'b0;
        else          irq <= en_next & (32'(count_next) <= 32'(irq_thresh_next));
    end
`endif

endmodule

// File: doc/axi_i2s_lite_slave.md
Name: axi_i2s_lite_slave

Overview:
AXI4-Lite responder for the I2S audio peripheral. It is the slave end of the register bus that the block-design master VIP drives. It decodes 4 word registers (control, clock divider, sample push, status). It buffers pushed audio samples in a small FIFO and presents them on a valid/ready stream to the I2S serializer.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32; other values unsupported)
C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select register, [1:0] ignored
FIFO_DEPTH, 8, sample FIFO entries, power of 2, >=2

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  4  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes (see Behaviour)
S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1
S_AXI_BRESP  out  2  / S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1
S_AXI_ARADDR  in  4  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1
S_AXI_RDATA  out  32  / S_AXI_RRESP  out  2  / S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1
smp_data  out  32  FIFO head sample
smp_valid  out  1  sample available
smp_ready  in  1  serializer accepts sample
i2s_en  out  1  CTRL.enable
clkdiv  out  16  CLKDIV[15:0]

Behaviour:
- Reset (ARESETN low, async): all outputs 0. The registers CTRL, CLKDIV, last_sample and ovf are cleared. FIFO pointers and count are cleared. A registered rst_done flag rises one ACLK edge after release. All READY outputs stay 0 until rst_done=1.
- Register map (word offset):
  - 0x0 CTRL RW: [0] enable; [1] flush, self-clearing and reads 0.
  - 0x4 CLKDIV RW: [15:0]; upper bits read 0.
  - 0x8 SAMPLE: a write pushes WDATA to the FIFO; a read returns the last accepted sample.
  - 0xC STATUS: [7:0] level, [8] full, [9] empty, [10] ovf sticky. RO except [10], which is write-1-to-clear.
- WSTRB: byte-honoured on CTRL and CLKDIV. On SAMPLE, WSTRB is ignored and the full word is pushed.
- Write channel:
  - AW and W are accepted independently into held registers aw_held and w_held.
  - AWREADY = rst_done & !aw_held & !BVALID. WREADY = rst_done & !w_held & !BVALID.
  - At the edge where both address and data are available (held or handshaking that cycle), the write commits. At that same edge BVALID rises and both held flags clear.
  - Latency: AW+W in the same cycle at edge N -> BVALID high after edge N.
  - BVALID holds until BREADY, and BRESP is stable while BVALID is high.
- BRESP:
  - OKAY (00) by default.
  - SLVERR (10) for a SAMPLE write while the FIFO is full. The sample is dropped, ovf is set and last_sample is unchanged.
- Read channel:
  - ARREADY = rst_done & !RVALID.
  - On AR handshake at edge N, RDATA is captured and RVALID=1 after edge N.
  - RDATA/RRESP (always OKAY) hold until RREADY.
  - A read and a write may proceed in the same cycle. The read returns the pre-write value.
- FIFO:
  - Circular buffer with wrap-around pointers; count ranges 0..FIFO_DEPTH.
  - smp_valid = enable & !empty; smp_data = mem[rd_ptr].
  - Pop occurs on smp_valid & smp_ready.
  - Full is evaluated on pre-cycle count. A push while full is rejected even if a pop occurs in the same cycle.
  - Push and pop together while not full: count is unchanged and both pointers advance.
  - Flush (write of CTRL[1]=1) clears the pointers and count at commit. Flush wins over a same-cycle pop. Flush does not clear ovf.
  - Enable=0 freezes the FIFO output; pushes are still accepted.
- Mid-operation reset: any pending AW/W/B/R is discarded and the FIFO is emptied.

Optional Feature:
AXI_I2S_IRQ_EN:
- Defined:
  - Adds output port irq (1 bit) and CTRL[11:8] irq_thresh (RW, reset 0).
  - irq is registered: irq = enable & (level <= irq_thresh), updated each edge from post-update level.
  - irq resets to 0.
- Undefined:
  - No irq port.
  - CTRL[11:8] reads 0 and writes to it are ignored.

Test Plan:
- Reset release, then write 0x4=0x0000_0020, 0x0=0x1, and read both -> RDATA 0x20 and 0x1, BRESP=OKAY, i2s_en=1, clkdiv=0x20.
- AW at cycle 0, W at cycle 3 -> AWREADY low cycles 1-3, BVALID high after cycle 3 edge; hold BREADY low 5 cycles -> BVALID/BRESP stable, no new AW accepted.
- enable=0, push 0x11..0x18 (8 writes) then a 9th 0x99 -> first 8 OKAY, 9th SLVERR; STATUS reads 0x508 (ovf, full, level 8); read 0x8 returns 0x18.
- Write STATUS=0x400, set enable=1, smp_ready=1 -> ovf clears; smp_data sequence 0x11..0x18 one per cycle; STATUS then 0x200.
- With smp_ready=1 and level=3, push 0x55 -> level stays 3 that cycle; then CTRL=0x3 (flush) -> level 0, smp_valid 0, CTRL reads 0x1.
- With AXI_I2S_IRQ_EN: irq_thresh=2, enable=1, FIFO level drains 4->2 -> irq rises the edge level reaches 2; push to 3 -> irq falls.
